// File: rtl/burst_trigger_gen.sv
// burst_trigger_gen: programmable burst sequencer for a gated-clock trigger.
// Lowers trigger (clock enabled) for 2*burst_len fastclk cycles, raises it
// for 2*gap_len cycles, and repeats for 'repeats' bursts.
// Optional feature macro: CONFIG_CONTINUOUS_EN (repeats=0 runs until abort).
module burst_trigger_gen #(
  parameter int CNT_W = 16,
  parameter int REP_W = 8
) (
  input  logic             fastclk,
  input  logic             reset_n,
  input  logic             start,
  input  logic             abort,
  input  logic [CNT_W-1:0] burst_len,
  input  logic [CNT_W-1:0] gap_len,
  input  logic [REP_W-1:0] repeats,
  output logic             trigger,
  output logic             busy,
  output logic             done,
  output logic [REP_W-1:0] burst_idx
);

`ifdef CONFIG_CONTINUOUS_EN
  localparam logic CONT_EN = 1'b1;
`else
  localparam logic CONT_EN = 1'b0;
`endif

  typedef enum logic [1:0] {S_IDLE, S_BURST, S_GAP} state_t;

  state_t           r_state, w_state_nxt;
  logic [CNT_W:0]   r_cnt, w_cnt_nxt;
  logic [CNT_W-1:0] r_blen, r_glen;
  logic [REP_W-1:0] r_reps;
  logic [REP_W-1:0] w_idx_nxt;
  logic             w_trig_nxt, w_done_nxt, w_latch;
  logic             w_start_ok, w_start_empty, w_last;
  logic [CNT_W:0]   w_burst_load, w_gap_load, w_new_load;

  // Counter loads: one slow period is two fastclk cycles, minus one for the load cycle
  assign w_burst_load = {r_blen, 1'b0} - 1'b1;
  assign w_gap_load   = {r_glen, 1'b0} - 1'b1;
  assign w_new_load   = {burst_len, 1'b0} - 1'b1;

  // A start runs only with a real burst length; repeats=0 runs only in continuous builds
  assign w_start_ok    = start && !abort && (burst_len != '0) && ((repeats != '0) || CONT_EN);
  assign w_start_empty = start && !abort && !w_start_ok;

  // Continuous mode (latched repeats=0) never reaches a last burst; idx wraps freely
  assign w_last = !(CONT_EN && (r_reps == '0)) && (burst_idx == REP_W'(r_reps - 1'b1));

  // Next-state and next-output logic
  always_comb begin
    w_state_nxt = r_state;
    w_cnt_nxt   = r_cnt;
    w_idx_nxt   = burst_idx;
    w_trig_nxt  = trigger;
    w_done_nxt  = 1'b0;
    w_latch     = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (w_start_ok) begin
          w_latch     = 1'b1;
          w_state_nxt = S_BURST;
          w_cnt_nxt   = w_new_load;
          w_idx_nxt   = '0;
          w_trig_nxt  = 1'b0;
        end else if (w_start_empty) begin
          w_done_nxt  = 1'b1;
        end
      end
      S_BURST: begin
        if (r_cnt != '0) begin
          w_cnt_nxt = r_cnt - 1'b1;
        end else if (w_last) begin
          w_state_nxt = S_IDLE;
          w_trig_nxt  = 1'b1;
          w_done_nxt  = 1'b1;
        end else if (r_glen != '0) begin
          w_state_nxt = S_GAP;
          w_cnt_nxt   = w_gap_load;
          w_trig_nxt  = 1'b1;
        end else begin
          w_idx_nxt   = burst_idx + 1'b1;
          w_cnt_nxt   = w_burst_load;
        end
      end
      S_GAP: begin
        if (r_cnt != '0) begin
          w_cnt_nxt = r_cnt - 1'b1;
        end else begin
          w_state_nxt = S_BURST;
          w_idx_nxt   = burst_idx + 1'b1;
          w_cnt_nxt   = w_burst_load;
          w_trig_nxt  = 1'b0;
        end
      end
      default: begin
        w_state_nxt = S_IDLE;
        w_trig_nxt  = 1'b1;
      end
    endcase
    // Abort ends a run silently; in IDLE it changes nothing
    if (abort && (r_state != S_IDLE)) begin
      w_state_nxt = S_IDLE;
      w_cnt_nxt   = '0;
      w_idx_nxt   = '0;
      w_trig_nxt  = 1'b1;
      w_done_nxt  = 1'b0;
    end
  end

  // State, counter and registered outputs
  always_ff @(posedge fastclk or negedge reset_n) begin
    if (!reset_n) begin
      r_state   <= S_IDLE;
      r_cnt     <= '0;
      trigger   <= 1'b1;
      busy      <= 1'b0;
      done      <= 1'b0;
      burst_idx <= '0;
    end else begin
      r_state   <= w_state_nxt;
      r_cnt     <= w_cnt_nxt;
      trigger   <= w_trig_nxt;
      busy      <= (w_state_nxt != S_IDLE);
      done      <= w_done_nxt;
      burst_idx <= w_idx_nxt;
    end
  end

  // Configuration captured at start; later input changes do not affect the run
  always_ff @(posedge fastclk or negedge reset_n) begin
    if (!reset_n) begin
      r_blen <= '0;
      r_glen <= '0;
      r_reps <= '0;
    end else if (w_latch) begin
      r_blen <= burst_len;
      r_glen <= gap_len;
      r_reps <= repeats;
    end
  end

endmodule

// File: tb/tb_burst_trigger_gen.sv
// Directed bench for burst_trigger_gen: a table of per-cycle vectors plus
// hand-written sequences for repeats=0 and asynchronous reset mid-run.
module tb_burst_trigger_gen;

  logic        fastclk = 1'b0;
  logic        reset_n;
  logic        start, abort;
  logic [15:0] burst_len, gap_len;
  logic [7:0]  repeats;
  logic        trigger, busy, done;
  logic [7:0]  burst_idx;

  int n_tests = 0;
  int n_fail  = 0;

  typedef struct {
    logic        s, a;
    logic [15:0] bl, gl;
    logic [7:0]  rp;
    int          n;
    logic        t, b, d;
    logic [7:0]  i;
  } vec_t;

  vec_t vecs[$];

  burst_trigger_gen #(.CNT_W(16), .REP_W(8)) dut (
    .fastclk(fastclk), .reset_n(reset_n), .start(start), .abort(abort),
    .burst_len(burst_len), .gap_len(gap_len), .repeats(repeats),
    .trigger(trigger), .busy(busy), .done(done), .burst_idx(burst_idx)
  );

  always #5 fastclk = ~fastclk;

  function automatic void add(logic s, logic a, int bl, int gl, int rp, int n,
                              logic t, logic b, logic d, int i);
    vec_t v;
    v.s = s; v.a = a; v.bl = 16'(bl); v.gl = 16'(gl); v.rp = 8'(rp);
    v.n = n; v.t = t; v.b = b; v.d = d; v.i = 8'(i);
    vecs.push_back(v);
  endfunction

  task automatic chk(string nm, logic t, logic b, logic d, logic [7:0] i);
    n_tests++;
    if ({trigger, busy, done, burst_idx} !== {t, b, d, i}) begin
      n_fail++;
      $display("FAIL %s: got trig=%0b busy=%0b done=%0b idx=%0d, want trig=%0b busy=%0b done=%0b idx=%0d",
               nm, trigger, busy, done, burst_idx, t, b, d, i);
    end
  endtask

  task automatic step();
    @(posedge fastclk);
    #1;
  endtask

  initial begin
    reset_n = 1'b0; start = 0; abort = 0;
    burst_len = 0; gap_len = 0; repeats = 0;

    // 3/2/2: trigger 0x6, 1x4, 0x6, then 1 with done
    add(1,0,3,2,2, 1, 0,1,0,0);
    add(0,0,3,2,2, 5, 0,1,0,0);
    add(0,0,3,2,2, 4, 1,1,0,0);
    add(0,0,3,2,2, 6, 0,1,0,1);
    add(0,0,3,2,2, 1, 1,0,1,1);
    add(0,0,3,2,2, 2, 1,0,0,1);
    // abort in IDLE: no effect, and it blocks a coincident start
    add(0,1,3,2,2, 1, 1,0,0,1);
    add(1,1,3,2,2, 1, 1,0,0,1);
    // 1/0/3: six contiguous low cycles, idx 0,1,2
    add(1,0,1,0,3, 1, 0,1,0,0);
    add(0,0,1,0,3, 1, 0,1,0,0);
    add(0,0,1,0,3, 2, 0,1,0,1);
    add(0,0,1,0,3, 2, 0,1,0,2);
    add(0,0,1,0,3, 1, 1,0,1,2);
    add(0,0,1,0,3, 1, 1,0,0,2);
    // burst_len=0: immediate done, trigger stays 1, idx held
    add(1,0,0,0,4, 1, 1,0,1,2);
    add(0,0,0,0,4, 2, 1,0,0,2);
    // config changes mid-run ignored; start while busy ignored
    add(1,0,2,1,3, 1, 0,1,0,0);
    add(0,0,9,1,3, 3, 0,1,0,0);
    add(1,0,9,1,3, 2, 1,1,0,0);
    add(0,0,9,5,3, 4, 0,1,0,1);
    add(0,0,9,5,3, 2, 1,1,0,1);
    add(0,0,9,5,3, 4, 0,1,0,2);
    add(0,0,9,5,3, 1, 1,0,1,2);
    // start accepted in the cycle after done; abort+start at burst cycle 5
    add(1,0,4,1,5, 1, 0,1,0,0);
    add(0,0,4,1,5, 3, 0,1,0,0);
    add(1,1,4,1,5, 1, 1,0,0,0);
    add(0,0,4,1,5, 3, 1,0,0,0);

    #12;
    chk("reset", 1'b1, 1'b0, 1'b0, 8'd0);
    @(negedge fastclk);
    reset_n = 1'b1;
    step();
    chk("post_reset_idle", 1'b1, 1'b0, 1'b0, 8'd0);

    for (int r = 0; r < vecs.size(); r++) begin
      start = vecs[r].s; abort = vecs[r].a;
      burst_len = vecs[r].bl; gap_len = vecs[r].gl; repeats = vecs[r].rp;
      for (int c = 0; c < vecs[r].n; c++) begin
        step();
        chk($sformatf("vec%0d.%0d", r, c), vecs[r].t, vecs[r].b, vecs[r].d, vecs[r].i);
      end
    end
    start = 0; abort = 0;

    // repeats=0 with burst_len=2
    burst_len = 16'd2; gap_len = 16'd0; repeats = 8'd0; start = 1'b1;
    step();
    start = 1'b0;
`ifdef CONFIG_CONTINUOUS_EN
    chk("cont_c0", 1'b0, 1'b1, 1'b0, 8'd0);
    for (int c = 1; c < 320; c++) begin
      step();
      chk($sformatf("cont_c%0d", c), 1'b0, 1'b1, 1'b0, 8'((c / 4) % 256));
    end
    abort = 1'b1;
    step();
    abort = 1'b0;
    chk("cont_abort", 1'b1, 1'b0, 1'b0, 8'd0);
`else
    chk("reps0_empty", 1'b1, 1'b0, 1'b1, 8'd0);
    step();
    chk("reps0_after", 1'b1, 1'b0, 1'b0, 8'd0);
`endif

    // asynchronous reset mid-burst
    burst_len = 16'd1; gap_len = 16'd0; repeats = 8'd3; start = 1'b1;
    step();
    start = 1'b0;
    step();
    step();
    chk("pre_reset_run", 1'b0, 1'b1, 1'b0, 8'd1);
    @(negedge fastclk);
    reset_n = 1'b0;
    #1;
    chk("async_reset", 1'b1, 1'b0, 1'b0, 8'd0);
    @(negedge fastclk);
    reset_n = 1'b1;
    for (int c = 0; c < 4; c++) begin
      step();
      chk($sformatf("reset_quiet%0d", c), 1'b1, 1'b0, 1'b0, 8'd0);
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
